// File: rtl/mem_sram_bridge.sv
// Cache-to-SRAM bridge: each 36-bit word is moved as two 18-bit half-word phases,
// high half (bits 0:17) first, with a programmable number of wait cycles per phase.
module mem_sram_bridge #(
    parameter int unsigned WAIT    = 2,
    parameter int unsigned MEMSIZE = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] mem_addr,
    input  logic [0:35] mem_write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [0:35] mem_read_data,
    output logic        mem_read_ack,
    output logic        mem_write_ack,
    output logic        mem_nxm,
    output logic [22:0] sram_addr,
    output logic [17:0] sram_dq_out,
    input  logic [17:0] sram_dq_in,
    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we
);

    localparam logic [3:0] WAIT_L = 4'(WAIT);

    typedef enum logic [2:0] {IDLE, HI, LO, ACK, NXM} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [21:0] addr_q, addr_n;
    logic [0:35] data_q, data_n;
    logic        wr_q, wr_n;
    logic [0:35] rdata_n;
    logic        rack_n, wack_n, nxm_n;
    logic [22:0] sa_n;
    logic [17:0] dq_n;
    logic        ce_n, oe_n, we_n;
    logic        in_range;

    assign in_range = (32'(mem_addr) < MEMSIZE);

    // Every output is computed one state ahead and registered, so the
    // pins always reflect the state being entered on that same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        data_n  = data_q;
        wr_n    = wr_q;
        rdata_n = mem_read_data;
        rack_n  = 1'b0;
        wack_n  = 1'b0;
        nxm_n   = 1'b0;
        sa_n    = sram_addr;
        dq_n    = sram_dq_out;
        ce_n    = 1'b0;
        oe_n    = 1'b0;
        we_n    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_n = mem_addr;
                    data_n = mem_write_data;
                    wr_n   = mem_write && !mem_read;
                    if (!in_range) begin
                        state_n = NXM;
                        nxm_n   = 1'b1;
                    end else begin
                        state_n = HI;
                        cnt_n   = WAIT_L;
                        ce_n    = 1'b1;
                        oe_n    = !wr_n;
                        we_n    = wr_n;
                        sa_n    = {addr_n, 1'b0};
                        dq_n    = data_n[0:17];
                    end
                end
            end
            HI: begin
                ce_n = 1'b1;
                oe_n = !wr_q;
                we_n = wr_q;
                if (cnt == 4'd0) begin
                    if (!wr_q) data_n[0:17] = sram_dq_in;
                    cnt_n   = WAIT_L;
                    state_n = LO;
                    sa_n    = {addr_q, 1'b1};
                    dq_n    = data_q[18:35];
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            LO: begin
                ce_n = 1'b1;
                oe_n = !wr_q;
                we_n = wr_q;
                if (cnt == 4'd0) begin
                    if (!wr_q) begin
                        data_n[18:35] = sram_dq_in;
                        rdata_n       = {data_q[0:17], sram_dq_in};
                    end
                    rack_n  = !wr_q;
                    wack_n  = wr_q;
                    ce_n    = 1'b0;
                    oe_n    = 1'b0;
                    we_n    = 1'b0;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACK:     state_n = IDLE;
            NXM:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= '0;
            data_q        <= '0;
            wr_q          <= 1'b0;
            mem_read_data <= '0;
            mem_read_ack  <= 1'b0;
            mem_write_ack <= 1'b0;
            mem_nxm       <= 1'b0;
            sram_addr     <= '0;
            sram_dq_out   <= '0;
            sram_ce       <= 1'b0;
            sram_oe       <= 1'b0;
            sram_we       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            addr_q        <= addr_n;
            data_q        <= data_n;
            wr_q          <= wr_n;
            mem_read_data <= rdata_n;
            mem_read_ack  <= rack_n;
            mem_write_ack <= wack_n;
            mem_nxm       <= nxm_n;
            sram_addr     <= sa_n;
            sram_dq_out   <= dq_n;
            sram_ce       <= ce_n;
            sram_oe       <= oe_n;
            sram_we       <= we_n;
        end
    end

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge (WAIT=2, MEMSIZE=1024) with a behavioural
// SRAM: fixed contents for word addresses 0..3, write-back storage elsewhere.
module tb_mem_sram_bridge;

    logic        clk;
    logic        reset;
    logic [21:0] mem_addr;
    logic [0:35] mem_write_data;
    logic        mem_read, mem_write;
    logic [0:35] mem_read_data;
    logic        mem_read_ack, mem_write_ack, mem_nxm;
    logic [22:0] sram_addr;
    logic [17:0] sram_dq_out, sram_dq_in;
    logic        sram_ce, sram_oe, sram_we;

    int vectors = 0;
    int miscompares = 0;

    mem_sram_bridge #(.WAIT(2), .MEMSIZE(1024)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .mem_write_ack(mem_write_ack), .mem_nxm(mem_nxm),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model and activity counters
    logic [17:0] wmem  [0:4095];
    bit          wrote [0:4095];
    int          we_cnt [0:4095];
    int rack_cnt = 0, wack_cnt = 0, nxm_cnt = 0, ce_cnt = 0, we_total = 0;

    function automatic logic [17:0] rom(input logic [11:0] a);
        case (a)
            12'd0:   rom = 18'o123456;
            12'd1:   rom = 18'o654321;
            12'd2:   rom = 18'o111111;
            12'd3:   rom = 18'o222222;
            12'd4:   rom = 18'o333333;
            12'd5:   rom = 18'o444444;
            12'd6:   rom = 18'o555555;
            12'd7:   rom = 18'o666666;
            default: rom = 18'o0;
        endcase
    endfunction

    assign sram_dq_in = (sram_ce && sram_oe) ?
        (wrote[sram_addr[11:0]] ? wmem[sram_addr[11:0]] : rom(sram_addr[11:0])) : 18'o0;

    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            wmem[sram_addr[11:0]]   = sram_dq_out;
            wrote[sram_addr[11:0]]  = 1'b1;
            we_cnt[sram_addr[11:0]] = we_cnt[sram_addr[11:0]] + 1;
            we_total = we_total + 1;
        end
        if (sram_ce) ce_cnt = ce_cnt + 1;
        if (mem_read_ack) rack_cnt = rack_cnt + 1;
        if (mem_write_ack) wack_cnt = wack_cnt + 1;
        if (mem_nxm) nxm_cnt = nxm_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [21:0] a, input logic [35:0] exp, input string tag);
        logic early;
        early    = 1'b0;
        mem_addr = a;
        mem_read = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) begin
                check({tag, " hi addr"}, 36'({a, 1'b0}), 36'(sram_addr));
                check({tag, " hi ctl"}, 36'({sram_ce, sram_oe, sram_we}), 36'(3'b110));
            end
            if (i == 4) check({tag, " lo addr"}, 36'(sram_addr), 36'({a, 1'b1}));
            if (i < 7 && (mem_read_ack || mem_write_ack || mem_nxm)) early = 1'b1;
        end
        check({tag, " early ack"}, 36'(early), 36'd0);
        check({tag, " ack"}, 36'({mem_read_ack, mem_write_ack, sram_ce}), 36'(3'b100));
        check({tag, " data"}, mem_read_data, exp);
        mem_read = 1'b0;
        tick();
        check({tag, " ack drop"}, 36'(mem_read_ack), 36'd0);
    endtask

    initial begin
        int t0, t1, wt0, n;
        logic [35:0] fill [0:3];
        fill[0] = 36'o123456654321;
        fill[1] = 36'o111111222222;
        fill[2] = 36'o333333444444;
        fill[3] = 36'o555555666666;
        reset = 1'b1;
        mem_addr = '0;
        mem_write_data = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        #12;
        check("reset ctl", 36'({sram_ce, sram_oe, sram_we, mem_read_ack, mem_write_ack, mem_nxm}), 36'd0);
        check("reset rdata", mem_read_data, 36'd0);
        check("reset sram", 36'({sram_addr, sram_dq_out}), 36'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // basic read immediately after reset release
        do_read(22'd0, 36'o123456654321, "read0");

        // write word 5
        t0 = rack_cnt;
        mem_addr = 22'd5;
        mem_write_data = 36'o777000111222;
        mem_write = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        check("wr early ack", 36'(mem_write_ack), 36'd0);
        tick();
        check("wr ack", 36'({mem_write_ack, mem_read_ack}), 36'(2'b10));
        mem_write = 1'b0;
        mem_write_data = 36'o0;
        tick();
        check("wr hi data", 36'(wmem[10]), 36'o777000);
        check("wr lo data", 36'(wmem[11]), 36'o111222);
        check("wr hi we cycles", 36'(we_cnt[10]), 36'd3);
        check("wr lo we cycles", 36'(we_cnt[11]), 36'd3);
        check("wr rdata kept", mem_read_data, 36'o123456654321);
        check("wr no read ack", 36'(rack_cnt - t0), 36'd0);

        // read of a non-existent address
        t0 = ce_cnt;
        t1 = rack_cnt + wack_cnt;
        mem_addr = 22'd1024;
        mem_read = 1'b1;
        tick();
        check("nxm pulse", 36'({mem_nxm, sram_ce}), 36'(2'b10));
        mem_read = 1'b0;
        tick();
        check("nxm drop", 36'(mem_nxm), 36'd0);
        for (int i = 0; i < 8; i++) tick();
        check("nxm no ce", 36'(ce_cnt - t0), 36'd0);
        check("nxm no ack", 36'(rack_cnt + wack_cnt - t1), 36'd0);
        check("nxm rdata kept", mem_read_data, 36'o123456654321);

        // read and write together act as a read
        t0 = wack_cnt;
        wt0 = we_total;
        mem_write = 1'b1;
        mem_write_data = 36'o070707070707;
        do_read(22'd1, 36'o111111222222, "rdwr");
        mem_write = 1'b0;
        check("rdwr no we", 36'(we_total - wt0), 36'd0);
        check("rdwr no wack", 36'(wack_cnt - t0), 36'd0);

        // cache line fill, request held
        mem_addr = 22'd0;
        mem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!mem_read_ack && n < 20);
            check($sformatf("fill%0d spacing", k), 36'(n), (k == 0) ? 36'd7 : 36'd8);
            check($sformatf("fill%0d data", k), mem_read_data, fill[k]);
            mem_addr = 22'(k + 1);
            if (k == 3) mem_read = 1'b0;
        end
        tick();

        // reset in the low phase of a write
        mem_addr = 22'd7;
        mem_write_data = 36'o123123321321;
        mem_write = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rst in lo", 36'({sram_addr, sram_we}), 36'({23'd15, 1'b1}));
        mem_write = 1'b0;
        reset = 1'b1;
        #1;
        check("rst async ctl", 36'({sram_ce, sram_oe, sram_we}), 36'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t0 = rack_cnt + wack_cnt + nxm_cnt;
        for (int i = 0; i < 12; i++) tick();
        check("rst no ack", 36'(rack_cnt + wack_cnt + nxm_cnt - t0), 36'd0);
        do_read(22'd0, 36'o123456654321, "read after rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_sram_bridge.md
MEM_SRAM_BRIDGE -- requirements
Module: mem_sram_bridge

Interface
REQ-001 Parameter: WAIT, default 2, SRAM wait cycles per half-word phase (0..15).
REQ-002 Parameter: MEMSIZE, default 2**20, installed memory in 36-bit words; word addresses >= MEMSIZE are non-existent.
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: mem_addr  in  `PADDR (22)  word address from cache.
REQ-006 Port: mem_write_data  in  `WORD [0:35]  write word from cache.
REQ-007 Port: mem_read, mem_write  in  1 each  level requests; held until ack or nxm.
REQ-008 Port: mem_read_data  out  `WORD  registered read word.
REQ-009 Port: mem_read_ack, mem_write_ack, mem_nxm  out  1 each  one-cycle registered pulses.
REQ-010 Port: sram_addr  out  23  half-word address {word address, half}; half 0 carries bits 0:17, half 1 carries bits 18:35.
REQ-011 Port: sram_dq_out  out  18; sram_dq_in  in  18; sram_ce, sram_oe, sram_we  out  1 each, active-high.

Function
REQ-012 States: IDLE, HI, LO, ACK, NXM; one-hot or encoded at implementer's choice; all outputs registered.
REQ-013 IDLE: no request -> stay IDLE, sram_ce/oe/we = 0.
REQ-014 IDLE with request: latch mem_addr, mem_write_data and op into holding registers; later input changes ignored until return to IDLE.
REQ-015 IDLE, mem_read and mem_write both high: treat as read; write not performed, no write ack.
REQ-016 IDLE, latched address >= MEMSIZE -> NXM; NXM asserts mem_nxm for exactly one cycle, no SRAM activity, no ack, then IDLE.
REQ-017 IDLE, valid address -> HI with wait counter loaded with WAIT.
REQ-018 HI: sram_addr = {addr,0}, sram_ce = 1, sram_oe = read, sram_we = write, sram_dq_out = data[0:17]; counter decrements each cycle; when counter == 0, read captures sram_dq_in into data[0:17], reload counter with WAIT, -> LO.
REQ-019 LO: identical to HI with half 1, data[18:35]; when counter == 0 -> ACK.
REQ-020 ACK: sram_ce/oe/we = 0; pulse mem_read_ack (read) or mem_write_ack (write) for one cycle; mem_read_data updated from holding register on a read in the same cycle; -> IDLE.
REQ-021 Latency: request sampled in IDLE at cycle N -> ack high during cycle N+2*(WAIT+1)+1 (N+7 at WAIT=2); nxm high during cycle N+1.
REQ-022 Back-to-back: after ACK/NXM one IDLE cycle always occurs; a request still high in that IDLE cycle is a new access (requester must drop or change it after ack).
REQ-023 mem_read_data holds its value between reads; writes and nxm never change it.
REQ-024 WAIT = 0: each phase lasts exactly one cycle.
REQ-025 Address compare uses full 22-bit width; MEMSIZE = 2**22 disables nxm.

Reset
REQ-026 reset high forces IDLE immediately (asynchronously); sram_ce/oe/we, all acks, mem_nxm = 0; sram_addr, sram_dq_out, mem_read_data, holding registers, counter = 0.
REQ-027 Reset mid-access aborts it: no ack, no nxm after release; a partially written word is not completed.
REQ-028 First request sampled in the first IDLE cycle after reset deasserts.

Verification
REQ-029 WAIT=2, SRAM model returns 18'o123456 for half 0, 18'o654321 for half 1, read addr 0 at cycle N -> mem_read_ack at N+7, mem_read_data = 36'o123456654321.
REQ-030 Write 36'o777000111222 to addr 5 -> SRAM sees half-addr 10 with 18'o777000, then 11 with 18'o111222, we high 3 cycles each; mem_write_ack at N+7; mem_read_data unchanged.
REQ-031 MEMSIZE=1024, read addr 1024 -> mem_nxm one cycle at N+1; no ack; sram_ce never asserted.
REQ-032 mem_read and mem_write both high -> read cycle only, mem_read_ack only, sram_we never asserted.
REQ-033 Reset asserted during LO of a write -> controls drop same cycle; no ack after release; next read completes normally at N+7.
REQ-034 Four back-to-back reads (cache line fill, addr 0..3, request held and address advanced on each ack) -> four acks spaced 8 cycles apart, correct data each.
